pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch_pkg.sv | 21 ++
 rtl/pc_fetch_if.sv | 34 +++
 rtl/pc_fetch.sv | 114 +++++++++++
 tb/tb_pc_fetch.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg
// Shared definitions for the PC / instruction-fetch stage.
//   PC_W             : program-counter width (11 bits)
//   INSTR_W          : instruction word width (16 bits)
//   RESET_PC_DEFAULT : default PC loaded on reset
//   state_e          : 2-bit fetch FSM state encoding
package pc_fetch_pkg;

    localparam int PC_W    = 11;
    localparam int INSTR_W = 16;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 11'h000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if
// Bundles the fetch stage's PC-mux, instruction-memory and decode signals.
//   master : the fetch stage (drives read_PC, imem_*, instr*, fetch_count)
//   slave  : the surroundings (PC mux, memory, decode, halt source)
// CNT_W must match the CNT_W of the connected pc_fetch.
interface pc_fetch_if
    import pc_fetch_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic [PC_W-1:0]    write_data_PC;
    logic [PC_W-1:0]    read_PC;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               decode_ready;
    logic               halt;
    logic [CNT_W-1:0]   fetch_count;

    modport master (
        input  write_data_PC, imem_ack, imem_data, decode_ready, halt,
        output read_PC, imem_req, imem_addr, instr, instr_valid, fetch_count
    );

    modport slave (
        output write_data_PC, imem_ack, imem_data, decode_ready, halt,
        input  read_PC, imem_req, imem_addr, instr, instr_valid, fetch_count
    );

endinterface

// File: rtl/pc_fetch.sv
// pc_fetch
// Holds the program counter, fetches one instruction at a time from
// instruction memory, presents it to decode with a valid/ready handshake
// and counts retired handshakes.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous active-high reset
//   bus   : pc_fetch_if.master (PC mux, imem request/ack, decode handshake,
//           halt, fetch_count)
// The PC only moves at a handshake, so the external PC-select mux always
// sees the PC of the instruction currently sitting in decode.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              CNT_W    = 16
) (
    input  logic          clk,
    input  logic          reset,
    pc_fetch_if.master    bus
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               req_q, req_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Next-state and next-output computation; req_d is derived from the
    // destination state so imem_req is a clean flop output.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = 1'b0;
        instr_d = instr_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                end
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_data;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    req_d   = 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.decode_ready) begin
                    pc_d    = bus.write_data_PC;
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (bus.halt) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_FETCH;
                        req_d   = 1'b1;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            S_HALT: begin
                valid_d = 1'b0;
                if (bus.halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // FSM and datapath registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            instr_q <= {INSTR_W{1'b0}};
            valid_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.read_PC     = pc_q;
    assign bus.imem_addr   = pc_q;
    assign bus.imem_req    = req_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch
// Directed scenarios with literal expectations followed by a randomized run.
// A transaction-level reference model predicts every output each cycle;
// outputs are compared on the falling edge.
module tb_pc_fetch;
    import pc_fetch_pkg::*;

    localparam int CNT_W = 8;
    localparam logic [PC_W-1:0] RST_PC = 11'h000;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;

    pc_fetch_if #(.CNT_W(CNT_W)) bus ();

    pc_fetch #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: "started" means the post-reset idle cycle has passed,
    // an outstanding request means waiting on memory, a held instruction
    // means waiting on decode, neither means halted.
    logic [PC_W-1:0]    m_pc;
    logic               m_req;
    logic               m_valid;
    logic [INSTR_W-1:0] m_instr;
    logic [CNT_W-1:0]   m_cnt;
    logic               m_started;

    always @(posedge clk) begin
        if (reset) begin
            m_pc <= RST_PC; m_req <= 1'b0; m_valid <= 1'b0;
            m_instr <= 16'h0000; m_cnt <= 8'h00; m_started <= 1'b0;
        end else if (!m_started) begin
            m_started <= 1'b1;
            m_req     <= !bus.halt;
        end else if (m_req) begin
            if (bus.imem_ack) begin
                m_instr <= bus.imem_data; m_valid <= 1'b1; m_req <= 1'b0;
            end
        end else if (m_valid) begin
            if (bus.decode_ready) begin
                m_pc <= bus.write_data_PC; m_valid <= 1'b0;
                m_cnt <= m_cnt + 8'd1; m_req <= !bus.halt;
            end
        end else if (!bus.halt) begin
            m_req <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_read_PC",     32'(bus.read_PC),     32'(m_pc));
            chk("m_imem_addr",   32'(bus.imem_addr),   32'(m_pc));
            chk("m_imem_req",    32'(bus.imem_req),    32'(m_req));
            chk("m_instr_valid", 32'(bus.instr_valid), 32'(m_valid));
            chk("m_instr",       32'(bus.instr),       32'(m_instr));
            chk("m_fetch_count", 32'(bus.fetch_count), 32'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.imem_ack = 1'b0; bus.decode_ready = 1'b0; bus.halt = 1'b0;
        bus.imem_data = 16'h0000; bus.write_data_PC = 11'h000;
    endtask

    // From a fetching cycle: zero-wait ack, then immediate handshake.
    task automatic handshake(input logic [PC_W-1:0] wd, input logic [INSTR_W-1:0] d);
        bus.imem_ack = 1'b1; bus.imem_data = d;
        step();
        bus.imem_ack = 1'b0; bus.decode_ready = 1'b1; bus.write_data_PC = wd;
        step();
        bus.decode_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clr_inputs();
        step();
        chk_en = 1'b1;
        chk("rst_pc", 32'(bus.read_PC), 32'h000);
        chk("rst_req", 32'(bus.imem_req), 32'h0);
        chk("rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_instr", 32'(bus.instr), 32'h0000);
        chk("rst_cnt", 32'(bus.fetch_count), 32'h00);

        // Zero-wait fetch of A5C3 and handshake to PC 001.
        reset = 1'b0;
        step();
        chk("f1_req", 32'(bus.imem_req), 32'h1);
        chk("f1_addr", 32'(bus.imem_addr), 32'h000);
        bus.imem_ack = 1'b1; bus.imem_data = 16'hA5C3;
        step();
        chk("f1_valid", 32'(bus.instr_valid), 32'h1);
        chk("f1_instr", 32'(bus.instr), 32'hA5C3);
        chk("f1_req_low", 32'(bus.imem_req), 32'h0);
        bus.imem_ack = 1'b0; bus.decode_ready = 1'b1; bus.write_data_PC = 11'h001;
        step();
        bus.decode_ready = 1'b0;
        chk("f1_pc", 32'(bus.read_PC), 32'h001);
        chk("f1_cnt", 32'(bus.fetch_count), 32'h01);

        // Ack delayed three cycles: request and address held.
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", 32'(bus.imem_req), 32'h1);
            chk("wait_addr", 32'(bus.imem_addr), 32'h001);
            chk("wait_valid", 32'(bus.instr_valid), 32'h0);
            step();
        end
        chk("wait_req4", 32'(bus.imem_req), 32'h1);
        bus.imem_ack = 1'b1; bus.imem_data = 16'h1234;
        step();
        bus.imem_ack = 1'b0;
        chk("wait_valid_after", 32'(bus.instr_valid), 32'h1);

        // Decode stalls for five cycles, stray ack is ignored.
        for (int i = 0; i < 5; i++) begin
            bus.imem_ack = i[0]; bus.imem_data = 16'hDEAD; bus.write_data_PC = 11'h555;
            step();
            chk("stall_instr", 32'(bus.instr), 32'h1234);
            chk("stall_req", 32'(bus.imem_req), 32'h0);
            chk("stall_pc", 32'(bus.read_PC), 32'h001);
        end
        bus.imem_ack = 1'b0;
        bus.decode_ready = 1'b1; bus.write_data_PC = 11'h2F0; bus.halt = 1'b1;
        step();
        bus.decode_ready = 1'b0;
        chk("hs_pc", 32'(bus.read_PC), 32'h2F0);
        chk("hs_cnt", 32'(bus.fetch_count), 32'h02);
        chk("halt_req", 32'(bus.imem_req), 32'h0);
        step();
        chk("halt_req2", 32'(bus.imem_req), 32'h0);
        chk("halt_valid", 32'(bus.instr_valid), 32'h0);
        bus.halt = 1'b0;
        step();
        chk("unhalt_req", 32'(bus.imem_req), 32'h1);
        chk("unhalt_addr", 32'(bus.imem_addr), 32'h2F0);

        // Reset with a simultaneous ack abandons the fetch.
        reset = 1'b1; bus.imem_ack = 1'b1; bus.imem_data = 16'hBEEF;
        step();
        reset = 1'b0; bus.imem_ack = 1'b0;
        chk("rfetch_valid", 32'(bus.instr_valid), 32'h0);
        chk("rfetch_pc", 32'(bus.read_PC), 32'(RST_PC));
        chk("rfetch_req", 32'(bus.imem_req), 32'h0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            bus.halt = ($urandom_range(0, 5) == 0);
            bus.imem_ack = $urandom_range(0, 1);
            bus.decode_ready = $urandom_range(0, 1);
            bus.imem_data = 16'($urandom);
            bus.write_data_PC = 11'($urandom);
            step();
        end

        // Run the counter up to FE, then cross 7FF -> 000 and the count wrap.
        clr_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 254; i++) begin
            handshake(11'($urandom), 16'($urandom));
        end
        chk("pre_cnt", 32'(bus.fetch_count), 32'hFE);
        handshake(11'h7FF, 16'h0F0F);
        chk("wrap_pc_7ff", 32'(bus.read_PC), 32'h7FF);
        chk("wrap_cnt_ff", 32'(bus.fetch_count), 32'hFF);
        handshake(11'h000, 16'hF0F0);
        chk("wrap_pc_000", 32'(bus.read_PC), 32'h000);
        chk("wrap_cnt_00", 32'(bus.fetch_count), 32'h00);
        chk("wrap_instr", 32'(bus.instr), 32'hF0F0);
        step();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
